tdp_port_ctrl: RTL and testbench

Request-side controller that sits directly upstream of the true dual-port 256x8 block RAM wrapper and drives both of its ports from one clock. It performs the following functions:
- Accepts independent valid/ready request streams from two clients (A, B).
- Registers BRAM port controls and returns read data with a response-valid strobe aligned to the RAM read latency.
- Arbitrates same-address write conflicts.
- Zero-fills the RAM after reset via a clear FSM.

---
 rtl/tdp_port_ctrl_if.sv | 38 +++
 rtl/tdp_port_ctrl.sv | 160 ++++++++++++++++
 tb/tb_tdp_port_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdp_port_ctrl_if.sv
// Client-side request/response bundle for the two ports of tdp_port_ctrl.
// Handshake: a request transfers on a rising edge where req_valid & req_ready
// are both high; while valid is high and ready is low the client keeps valid
// asserted and holds we/addr/wdata unchanged. Responses carry no backpressure:
// rsp_valid is a one-cycle strobe and rsp_rdata must be taken in that cycle.
interface tdp_port_ctrl_if;
   logic       a_req_valid;
   logic       a_req_ready;
   logic       a_req_we;
   logic [7:0] a_req_addr;
   logic [7:0] a_req_wdata;
   logic       a_rsp_valid;
   logic [7:0] a_rsp_rdata;

   logic       b_req_valid;
   logic       b_req_ready;
   logic       b_req_we;
   logic [7:0] b_req_addr;
   logic [7:0] b_req_wdata;
   logic       b_rsp_valid;
   logic [7:0] b_rsp_rdata;

   // Client side: issues requests, receives ready and responses.
   modport master (
      output a_req_valid, a_req_we, a_req_addr, a_req_wdata,
      output b_req_valid, b_req_we, b_req_addr, b_req_wdata,
      input  a_req_ready, a_rsp_valid, a_rsp_rdata,
      input  b_req_ready, b_rsp_valid, b_rsp_rdata
   );

   // Controller side.
   modport slave (
      input  a_req_valid, a_req_we, a_req_addr, a_req_wdata,
      input  b_req_valid, b_req_we, b_req_addr, b_req_wdata,
      output a_req_ready, a_rsp_valid, a_rsp_rdata,
      output b_req_ready, b_rsp_valid, b_rsp_rdata
   );
endinterface

// File: rtl/tdp_port_ctrl.sv
// Request-side controller for a true dual-port 256x8 BRAM. Two clients issue
// valid/ready requests; each is registered onto its own RAM port. Reads return
// a one-cycle rsp_valid strobe aligned to the RAM read latency. A same-address
// conflict involving a write stalls client B so A wins. After reset an
// optional sweep writes CLEAR_VALUE to every address, two per cycle.
module tdp_port_ctrl #(
   parameter int         READ_LATENCY   = 1,
   parameter bit         CLEAR_ON_RESET = 1'b1,
   parameter logic [7:0] CLEAR_VALUE    = 8'h00,
   parameter int         CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   tdp_port_ctrl_if.slave   req,
   output logic             bram_en_a,
   output logic             bram_we_a,
   output logic [7:0]       bram_addr_a,
   output logic [7:0]       bram_din_a,
   input  logic [7:0]       bram_dout_a,
   output logic             bram_en_b,
   output logic             bram_we_b,
   output logic [7:0]       bram_addr_b,
   output logic [7:0]       bram_din_b,
   input  logic [7:0]       bram_dout_b,
   output logic             init_done,
   output logic [CNT_W-1:0] collision_cnt,
   output logic             dbg_state
);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

   state_t                  r_state;
   logic [6:0]              r_idx;
   logic                    r_init_done;
   logic                    r_en_a, r_we_a;
   logic [7:0]              r_addr_a, r_din_a;
   logic                    r_en_b, r_we_b;
   logic [7:0]              r_addr_b, r_din_b;
   logic [READ_LATENCY-1:0] r_rvld_a, r_rvld_b;
   logic [CNT_W-1:0]        r_cnt;

   logic w_run;
   logic w_collision;
   logic w_a_acc;
   logic w_b_acc;
   logic w_cnt_sat;

   // Acceptance: A always wins; B is held whenever it would touch the same
   // address as A in the same cycle and at least one of them writes.
   assign w_run       = (r_state == ST_RUN);
   assign w_collision = req.a_req_valid & req.b_req_valid &
                        (req.a_req_addr == req.b_req_addr) &
                        (req.a_req_we | req.b_req_we);
   assign w_a_acc     = w_run & req.a_req_valid;
   assign w_b_acc     = w_run & req.b_req_valid & ~w_collision;
   assign w_cnt_sat   = &r_cnt;

   assign req.a_req_ready = w_run;
   assign req.b_req_ready = w_run & ~w_collision;

   // Control FSM: clear sweep then steady-state registration of port controls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RST_STATE;
         r_idx       <= '0;
         r_init_done <= 1'b0;
         r_en_a      <= 1'b0;
         r_we_a      <= 1'b0;
         r_addr_a    <= '0;
         r_din_a     <= '0;
         r_en_b      <= 1'b0;
         r_we_b      <= 1'b0;
         r_addr_b    <= '0;
         r_din_b     <= '0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               // Even addresses on port A, odd on port B: 128 cycles cover 256.
               r_en_a   <= 1'b1;
               r_we_a   <= 1'b1;
               r_addr_a <= {r_idx, 1'b0};
               r_din_a  <= CLEAR_VALUE;
               r_en_b   <= 1'b1;
               r_we_b   <= 1'b1;
               r_addr_b <= {r_idx, 1'b1};
               r_din_b  <= CLEAR_VALUE;
               r_idx    <= r_idx + 7'd1;
               if (r_idx == 7'd127) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end
            end
            default: begin
               r_init_done <= 1'b1;
               // Idle cycles drop en/we but leave addr/din as they were.
               r_en_a <= w_a_acc;
               r_we_a <= w_a_acc & req.a_req_we;
               if (w_a_acc) begin
                  r_addr_a <= req.a_req_addr;
                  r_din_a  <= req.a_req_wdata;
               end
               r_en_b <= w_b_acc;
               r_we_b <= w_b_acc & req.b_req_we;
               if (w_b_acc) begin
                  r_addr_b <= req.b_req_addr;
                  r_din_b  <= req.b_req_wdata;
               end
            end
         endcase
      end
   end

   // Read-valid pipelines: a read enters when the RAM samples it and leaves
   // READ_LATENCY edges later, in step with dout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvld_a <= '0;
         r_rvld_b <= '0;
      end else begin
         r_rvld_a[0] <= r_en_a & ~r_we_a;
         r_rvld_b[0] <= r_en_b & ~r_we_b;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_rvld_a[i] <= r_rvld_a[i-1];
            r_rvld_b[i] <= r_rvld_b[i-1];
         end
      end
   end

   // Saturating count of cycles in which B was stalled by a collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_run && w_collision && !w_cnt_sat) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign bram_en_a     = r_en_a;
   assign bram_we_a     = r_we_a;
   assign bram_addr_a   = r_addr_a;
   assign bram_din_a    = r_din_a;
   assign bram_en_b     = r_en_b;
   assign bram_we_b     = r_we_b;
   assign bram_addr_b   = r_addr_b;
   assign bram_din_b    = r_din_b;
   assign init_done     = r_init_done;
   assign collision_cnt = r_cnt;
   assign dbg_state     = r_state;

   assign req.a_rsp_valid = r_rvld_a[READ_LATENCY-1];
   assign req.a_rsp_rdata = bram_dout_a;
   assign req.b_rsp_valid = r_rvld_b[READ_LATENCY-1];
   assign req.b_rsp_rdata = bram_dout_b;

endmodule

// File: tb/tb_tdp_port_ctrl.sv
// Bench for tdp_port_ctrl. Two instances share the clock:
//   dut1: READ_LATENCY=1, clear sweep enabled, CNT_W=16
//   dut2: READ_LATENCY=2, no clear sweep, CNT_W=4
// Each has a behavioural read-first 256x8 dual-port RAM with matching latency.
// Expected read responses {due_cycle, data} go into per-port queues when a
// request is seen accepted; a negedge monitor pops them on every rsp_valid.
module tb_tdp_port_ctrl;

   localparam int RL1 = 1;
   localparam int RL2 = 2;

   logic clk = 1'b0;
   logic rst_n1;
   logic rst_n2;
   logic fill;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tdp_port_ctrl_if if1 ();
   tdp_port_ctrl_if if2 ();

   logic        en_a1, we_a1, en_b1, we_b1, init_done1, st1;
   logic [7:0]  addr_a1, din_a1, dout_a1, addr_b1, din_b1, dout_b1;
   logic [15:0] cnt1;
   logic        en_a2, we_a2, en_b2, we_b2, init_done2, st2;
   logic [7:0]  addr_a2, din_a2, dout_a2, addr_b2, din_b2, dout_b2;
   logic [3:0]  cnt2;

   tdp_port_ctrl #(
      .READ_LATENCY(RL1), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00), .CNT_W(16)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n1), .req(if1),
      .bram_en_a(en_a1), .bram_we_a(we_a1), .bram_addr_a(addr_a1),
      .bram_din_a(din_a1), .bram_dout_a(dout_a1),
      .bram_en_b(en_b1), .bram_we_b(we_b1), .bram_addr_b(addr_b1),
      .bram_din_b(din_b1), .bram_dout_b(dout_b1),
      .init_done(init_done1), .collision_cnt(cnt1), .dbg_state(st1)
   );

   tdp_port_ctrl #(
      .READ_LATENCY(RL2), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(8'h00), .CNT_W(4)
   ) u_dut2 (
      .clk(clk), .rst_n(rst_n2), .req(if2),
      .bram_en_a(en_a2), .bram_we_a(we_a2), .bram_addr_a(addr_a2),
      .bram_din_a(din_a2), .bram_dout_a(dout_a2),
      .bram_en_b(en_b2), .bram_we_b(we_b2), .bram_addr_b(addr_b2),
      .bram_din_b(din_b2), .bram_dout_b(dout_b2),
      .init_done(init_done2), .collision_cnt(cnt2), .dbg_state(st2)
   );

   // ---------------- RAM models (read-first) ----------------
   logic [7:0] mem1 [256];
   logic [7:0] ram_qa1, ram_qb1;
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 256; i++) mem1[i] <= 8'hEE;
      end else begin
         if (en_a1) begin
            if (we_a1) mem1[addr_a1] <= din_a1;
            else       ram_qa1 <= mem1[addr_a1];
         end
         if (en_b1) begin
            if (we_b1) mem1[addr_b1] <= din_b1;
            else       ram_qb1 <= mem1[addr_b1];
         end
      end
   end
   assign dout_a1 = ram_qa1;
   assign dout_b1 = ram_qb1;

   logic [7:0] mem2 [256];
   logic [7:0] ram_qa2, ram_qb2, ram_qa2_d, ram_qb2_d;
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 256; i++) mem2[i] <= 8'h33;
      end else begin
         if (en_a2) begin
            if (we_a2) mem2[addr_a2] <= din_a2;
            else       ram_qa2 <= mem2[addr_a2];
         end
         if (en_b2) begin
            if (we_b2) mem2[addr_b2] <= din_b2;
            else       ram_qb2 <= mem2[addr_b2];
         end
      end
      ram_qa2_d <= ram_qa2;
      ram_qb2_d <= ram_qb2;
   end
   assign dout_a2 = ram_qa2_d;
   assign dout_b2 = ram_qb2_d;

   // ---------------- scoreboard ----------------
   logic [39:0] exp_a1_q[$];
   logic [39:0] exp_b1_q[$];
   logic [39:0] exp_a2_q[$];
   logic [39:0] exp_b2_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic rsp_chk(input string nm, input logic [39:0] e, input logic [7:0] d);
      chk({nm, "_data"}, {24'd0, d}, {24'd0, e[7:0]});
      chk({nm, "_cycle"}, cyc, e[39:8]);
   endtask

   task automatic unexp(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected rsp_valid, got 1 expected 0 (t=%0t)", nm, $time);
   endtask

   // Monitor: every strobe must match the oldest pending expectation.
   always @(negedge clk) begin
      if (if1.a_rsp_valid === 1'b1) begin
         if (exp_a1_q.size() == 0) unexp("a1_rsp");
         else rsp_chk("a1_rsp", exp_a1_q.pop_front(), if1.a_rsp_rdata);
      end
      if (if1.b_rsp_valid === 1'b1) begin
         if (exp_b1_q.size() == 0) unexp("b1_rsp");
         else rsp_chk("b1_rsp", exp_b1_q.pop_front(), if1.b_rsp_rdata);
      end
      if (if2.a_rsp_valid === 1'b1) begin
         if (exp_a2_q.size() == 0) unexp("a2_rsp");
         else rsp_chk("a2_rsp", exp_a2_q.pop_front(), if2.a_rsp_rdata);
      end
      if (if2.b_rsp_valid === 1'b1) begin
         if (exp_b2_q.size() == 0) unexp("b2_rsp");
         else rsp_chk("b2_rsp", exp_b2_q.pop_front(), if2.b_rsp_rdata);
      end
   end

   // ---------------- driver tasks ----------------
   // One cycle of stimulus: drive after the edge, sample ready mid-cycle; an
   // accepted read is due RL edges after the acceptance edge.
   task automatic drive1(input logic av, input logic awe, input logic [7:0] aad,
                         input logic [7:0] awd, input logic [7:0] aex,
                         input logic bv, input logic bwe, input logic [7:0] bad,
                         input logic [7:0] bwd, input logic [7:0] bex,
                         output logic ardy, output logic brdy);
      @(posedge clk);
      #1;
      if1.a_req_valid = av;  if1.a_req_we = awe;  if1.a_req_addr = aad;  if1.a_req_wdata = awd;
      if1.b_req_valid = bv;  if1.b_req_we = bwe;  if1.b_req_addr = bad;  if1.b_req_wdata = bwd;
      @(negedge clk);
      ardy = if1.a_req_ready;
      brdy = if1.b_req_ready;
      if (av && ardy && !awe) exp_a1_q.push_back({32'(cyc + 1 + RL1), aex});
      if (bv && brdy && !bwe) exp_b1_q.push_back({32'(cyc + 1 + RL1), bex});
   endtask

   task automatic drive2(input logic av, input logic awe, input logic [7:0] aad,
                         input logic [7:0] awd, input logic [7:0] aex,
                         input logic bv, input logic bwe, input logic [7:0] bad,
                         input logic [7:0] bwd, input logic [7:0] bex,
                         output logic ardy, output logic brdy);
      @(posedge clk);
      #1;
      if2.a_req_valid = av;  if2.a_req_we = awe;  if2.a_req_addr = aad;  if2.a_req_wdata = awd;
      if2.b_req_valid = bv;  if2.b_req_we = bwe;  if2.b_req_addr = bad;  if2.b_req_wdata = bwd;
      @(negedge clk);
      ardy = if2.a_req_ready;
      brdy = if2.b_req_ready;
      if (av && ardy && !awe) exp_a2_q.push_back({32'(cyc + 1 + RL2), aex});
      if (bv && brdy && !bwe) exp_b2_q.push_back({32'(cyc + 1 + RL2), bex});
   endtask

   logic       ar, br;
   int         bad, w;
   logic [6:0] ix;

   task automatic idle1(input int n);
      logic x, y;
      repeat (n) drive1(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, x, y);
   endtask
   task automatic idle2(input int n);
      logic x, y;
      repeat (n) drive2(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, x, y);
   endtask
   task automatic rd_a1(input logic [7:0] ad, input logic [7:0] ex);
      logic x, y;
      drive1(1, 0, ad, 8'h00, ex, 0, 0, 8'h00, 8'h00, 8'h00, x, y);
   endtask
   task automatic wr_a1(input logic [7:0] ad, input logic [7:0] d);
      logic x, y;
      drive1(1, 1, ad, d, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, x, y);
   endtask
   task automatic rd_b1(input logic [7:0] ad, input logic [7:0] ex);
      logic x, y;
      drive1(0, 0, 8'h00, 8'h00, 8'h00, 1, 0, ad, 8'h00, ex, x, y);
   endtask
   task automatic wr_b1(input logic [7:0] ad, input logic [7:0] d);
      logic x, y;
      drive1(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, ad, d, 8'h00, x, y);
   endtask
   task automatic rd_a2(input logic [7:0] ad, input logic [7:0] ex);
      logic x, y;
      drive2(1, 0, ad, 8'h00, ex, 0, 0, 8'h00, 8'h00, 8'h00, x, y);
   endtask
   task automatic wr_a2(input logic [7:0] ad, input logic [7:0] d);
      logic x, y;
      drive2(1, 1, ad, d, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, x, y);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_n1 = 1'b0;
      rst_n2 = 1'b0;
      fill   = 1'b1;
      if1.a_req_valid = 0; if1.a_req_we = 0; if1.a_req_addr = 0; if1.a_req_wdata = 0;
      if1.b_req_valid = 0; if1.b_req_we = 0; if1.b_req_addr = 0; if1.b_req_wdata = 0;
      if2.a_req_valid = 0; if2.a_req_we = 0; if2.a_req_addr = 0; if2.a_req_wdata = 0;
      if2.b_req_valid = 0; if2.b_req_we = 0; if2.b_req_addr = 0; if2.b_req_wdata = 0;
      repeat (2) @(posedge clk);
      #1 fill = 1'b0;
      @(negedge clk);

      // Reset values of dut1.
      chk("rst_bram_en_a", {31'd0, en_a1}, 0);
      chk("rst_bram_we_b", {31'd0, we_b1}, 0);
      chk("rst_init_done", {31'd0, init_done1}, 0);
      chk("rst_cnt", {16'd0, cnt1}, 0);
      chk("rst_rsp_valid", {31'd0, if1.a_rsp_valid}, 0);
      chk("rst_state_clear", {31'd0, st1}, 0);

      // Clear sweep: 128 cycles of ready low with both ports writing 0.
      rst_n1 = 1'b1;
      bad = 0;
      for (int i = 0; i < 128; i++) begin
         if (if1.a_req_ready !== 1'b0 || if1.b_req_ready !== 1'b0 || init_done1 !== 1'b0) bad++;
         if (i > 0) begin
            ix = 7'(i - 1);
            if (en_a1 !== 1'b1 || we_a1 !== 1'b1 || addr_a1 !== {ix, 1'b0} || din_a1 !== 8'h00) bad++;
            if (en_b1 !== 1'b1 || we_b1 !== 1'b1 || addr_b1 !== {ix, 1'b1} || din_b1 !== 8'h00) bad++;
         end
         @(negedge clk);
      end
      chk("clear_sweep", bad, 0);
      chk("init_done_after_128", {31'd0, init_done1}, 1);
      chk("run_a_ready", {31'd0, if1.a_req_ready}, 1);
      chk("run_b_ready", {31'd0, if1.b_req_ready}, 1);

      // Cleared boundary addresses read back as zero.
      rd_a1(8'h00, 8'h00);
      rd_a1(8'h7F, 8'h00);
      rd_a1(8'h80, 8'h00);
      rd_a1(8'hFF, 8'h00);
      idle1(3);

      // Write then read next cycle, latency 1.
      wr_a1(8'h10, 8'h5A);
      rd_a1(8'h10, 8'h5A);
      idle1(3);

      // Same-address write/write: A wins, B stalls one cycle then lands.
      drive1(1, 1, 8'h40, 8'h11, 8'h00, 1, 1, 8'h40, 8'h22, 8'h00, ar, br);
      chk("t3_a_ready", {31'd0, ar}, 1);
      chk("t3_b_stalled", {31'd0, br}, 0);
      drive1(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h40, 8'h22, 8'h00, ar, br);
      chk("t3_b_retry_ready", {31'd0, br}, 1);
      idle1(1);
      chk("t3_cnt", {16'd0, cnt1}, 1);
      rd_a1(8'h40, 8'h22);
      idle1(3);

      // Same-address read/read: no collision, simultaneous responses.
      drive1(1, 0, 8'h40, 8'h00, 8'h22, 1, 0, 8'h40, 8'h00, 8'h22, ar, br);
      chk("t4_a_ready", {31'd0, ar}, 1);
      chk("t4_b_ready", {31'd0, br}, 1);
      idle1(3);
      chk("t4_cnt_unchanged", {16'd0, cnt1}, 1);

      // Back-to-back B reads, in order.
      for (int i = 1; i <= 4; i++) wr_b1(8'(i), 8'(8'hA0 + i));
      for (int i = 1; i <= 4; i++) rd_b1(8'(i), 8'(8'hA0 + i));
      idle1(3);
      chk("t5_drained", exp_b1_q.size(), 0);

      // Reset with reads in flight: second read must never respond.
      rd_b1(8'h01, 8'hA1);
      rd_b1(8'h02, 8'hA2);
      @(posedge clk);
      #1 if1.b_req_valid = 1'b0;
      @(negedge clk);
      #1 rst_n1 = 1'b0;
      exp_b1_q.delete();
      @(negedge clk);
      chk("t5_rst_rsp_valid", {31'd0, if1.b_rsp_valid}, 0);
      chk("t5_rst_init_done", {31'd0, init_done1}, 0);
      chk("t5_rst_state_clear", {31'd0, st1}, 0);
      chk("t5_rst_b_ready", {31'd0, if1.b_req_ready}, 0);
      chk("t5_rst_cnt", {16'd0, cnt1}, 0);
      repeat (3) @(negedge clk);
      rst_n1 = 1'b1;
      w = 0;
      while (init_done1 !== 1'b1 && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk("t5_reinit_done", {31'd0, init_done1}, 1);
      chk("t5_reclear_cycles", w, 128);
      rd_b1(8'h01, 8'h00);
      idle1(3);

      // dut2: no clear sweep, init_done on the first edge after reset.
      chk("d2_rst_init_done", {31'd0, init_done2}, 0);
      chk("d2_rst_cnt", {28'd0, cnt2}, 0);
      rst_n2 = 1'b1;
      @(negedge clk);
      chk("d2_init_first_edge", {31'd0, init_done2}, 1);
      chk("d2_state_run", {31'd0, st2}, 1);

      // Write then read, latency 2.
      wr_a2(8'h10, 8'h5A);
      rd_a2(8'h10, 8'h5A);
      idle2(4);

      // Persistent collision: counter saturates at 4'hF, B stalled throughout.
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         drive2(1, 1, 8'h50, 8'h66, 8'h00, 1, 1, 8'h50, 8'h77, 8'h00, ar, br);
         if (br !== 1'b0) bad++;
         if (i == 5) chk("t6_cnt_mid", {28'd0, cnt2}, 5);
      end
      chk("t6_b_stalled", bad, 0);
      drive2(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h50, 8'h77, 8'h00, ar, br);
      chk("t6_b_released", {31'd0, br}, 1);
      idle2(1);
      chk("t6_cnt_saturated", {28'd0, cnt2}, 32'hF);
      rd_a2(8'h50, 8'h77);
      idle2(4);

      chk("end_q_a1_empty", exp_a1_q.size(), 0);
      chk("end_q_b1_empty", exp_b1_q.size(), 0);
      chk("end_q_a2_empty", exp_a2_q.size(), 0);
      chk("end_q_b2_empty", exp_b2_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
